// File: rtl/pwm_tone_gen.sv
// Multi-channel PWM tone generator: per-channel period, high time, volume shift and enable.
// Optional macro PWM_SYNC_UPDATE_EN defers active-set updates to the channel wrap (glitch-free).
module pwm_tone_gen #(
  parameter int W     = 12,
  parameter int CH    = 4,
  parameter int VOL_W = 3,
  parameter int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [W-1:0]    cfg_period,
  input  logic [W-1:0]    cfg_htime,
  input  logic [VOL_W-1:0] cfg_vol,
  input  logic            cfg_en,
  output logic [CH-1:0]   wave,
  output logic [CH-1:0]   pulse
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0]     sh_period, sh_htime;
    logic [VOL_W-1:0] sh_vol;
    logic [W-1:0]     act_period, act_htime;
    logic [VOL_W-1:0] act_vol;
    logic [W-1:0]     nxt_period, nxt_htime;
    logic [VOL_W-1:0] nxt_vol;
    logic [W-1:0]     cnt, eff_h;
    logic             en, en_d, run, wr, wrap, act_load;
    logic             wave_q, pulse_q;

    always_comb begin
      wr    = cfg_we && (cfg_ch == CH_W'(c));
      // en_d delays counting by one cycle so an enable at edge N restarts from cnt=0 at N+1
      run   = en && en_d;
      wrap  = (cnt >= act_period);
      eff_h = act_htime >> act_vol;
`ifdef PWM_SYNC_UPDATE_EN
      act_load = wrap || !run;
      if (wr) begin
        nxt_period = cfg_period;
        nxt_htime  = cfg_htime;
        nxt_vol    = cfg_vol;
      end else begin
        nxt_period = sh_period;
        nxt_htime  = sh_htime;
        nxt_vol    = sh_vol;
      end
`else
      act_load   = wr;
      nxt_period = cfg_period;
      nxt_htime  = cfg_htime;
      nxt_vol    = cfg_vol;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_period  <= '0;
        sh_htime   <= '0;
        sh_vol     <= '0;
        act_period <= '0;
        act_htime  <= '0;
        act_vol    <= '0;
        en         <= 1'b0;
        en_d       <= 1'b0;
        cnt        <= '0;
        wave_q     <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        if (wr) begin
          sh_period <= cfg_period;
          sh_htime  <= cfg_htime;
          sh_vol    <= cfg_vol;
          en        <= cfg_en;
        end
        en_d <= en;
        if (act_load) begin
          act_period <= nxt_period;
          act_htime  <= nxt_htime;
          act_vol    <= nxt_vol;
        end
        if (sync || !run) begin
          cnt     <= '0;
          wave_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          wave_q  <= (cnt < eff_h);
          pulse_q <= wrap;
          cnt     <= wrap ? '0 : cnt + 1'b1;
        end
      end
    end

    assign wave[c]  = wave_q;
    assign pulse[c] = pulse_q;
  end

endmodule

// File: tb/tb_pwm_tone_gen.sv
// Directed self-checking bench for pwm_tone_gen: vector table plus multi-cycle sequences.
module tb_pwm_tone_gen;
  localparam int W = 12;
  localparam int CH = 4;
  localparam int VOL_W = 3;
  localparam int CH_W = 3;

  logic             clk;
  logic             rst;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [W-1:0]     cfg_period;
  logic [W-1:0]     cfg_htime;
  logic [VOL_W-1:0] cfg_vol;
  logic             cfg_en;
  logic [CH-1:0]    wave;
  logic [CH-1:0]    pulse;

  int n_pass = 0;
  int n_total = 0;

  pwm_tone_gen #(.W(W), .CH(CH), .VOL_W(VOL_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_htime(cfg_htime), .cfg_vol(cfg_vol),
    .cfg_en(cfg_en), .wave(wave), .pulse(pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int period;
    int htime;
    int vol;
    int en;
    int window;
    int exp_pulses;
    int exp_highs;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input int v, input int e);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = W'(p);
    cfg_htime  = W'(h);
    cfg_vol    = VOL_W'(v);
    cfg_en     = e[0];
    step();
    cfg_we     = 1'b0;
  endtask

  // Steps until pulse[c] is seen; n = steps taken, or -1 if the budget expires.
  task automatic wait_pulse(input int c, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (pulse[c]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int np;
    int nh;
    int first[CH];
    int per[CH];

    vecs[0] = '{0, 9, 4, 0, 1, 30, 3, 12};
    vecs[1] = '{1, 99, 80, 2, 1, 100, 1, 20};
    vecs[2] = '{1, 99, 80, 7, 1, 100, 1, 0};
    vecs[3] = '{2, 0, 1, 0, 1, 10, 10, 10};
    vecs[4] = '{3, 6, 10, 0, 1, 7, 1, 7};
    vecs[5] = '{3, 7, 12, 2, 1, 16, 2, 6};
    vecs[6] = '{3, 7, 12, 2, 0, 10, 0, 0};

    rst = 1'b1; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_period = '0; cfg_htime = '0; cfg_vol = '0; cfg_en = 1'b0;
    repeat (3) step();
    check("reset_wave", int'(wave), 0);
    check("reset_pulse", int'(pulse), 0);
    rst = 1'b0;
    step();

    // Out-of-range channel writes must not enable anything
    cfg_write(4, 0, 1, 0, 1);
    cfg_write(7, 0, 1, 0, 1);
    repeat (5) step();
    check("oor_wave", int'(wave), 0);
    check("oor_pulse", int'(pulse), 0);

    // Enable latency: write at edge N, first wave at N+2
    cfg_write(0, 9, 4, 0, 1);
    check("en_wave_n", int'(wave[0]), 0);
    step();
    check("en_wave_n1", int'(wave[0]), 0);
    step();
    check("en_wave_n2", int'(wave[0]), 1);
    wait_pulse(0, 20, n);
    check("first_pulse_gap", n, 9);
    wait_pulse(0, 20, n);
    check("pulse_spacing10", n, 10);

    // Lower period while cnt=3
    repeat (3) step();
    cfg_write(0, 4, 2, 0, 1);
    wait_pulse(0, 20, n);
`ifdef PWM_SYNC_UPDATE_EN
    check("shrink_first_wrap", n, 6);
`else
    check("shrink_first_wrap", n, 1);
`endif
    wait_pulse(0, 20, n);
    check("shrink_spacing5", n, 5);

    for (int i = 0; i < 7; i++) begin
      cfg_write(vecs[i].ch, vecs[i].period, vecs[i].htime, vecs[i].vol, vecs[i].en);
      repeat (205) step();
      np = 0;
      nh = 0;
      for (int k = 0; k < vecs[i].window; k++) begin
        step();
        if (pulse[vecs[i].ch]) np++;
        if (wave[vecs[i].ch]) nh++;
      end
      check($sformatf("vec%0d_pulses", i), np, vecs[i].exp_pulses);
      check($sformatf("vec%0d_highs", i), nh, vecs[i].exp_highs);
    end

    // Sync restart: all channels in lockstep afterwards
    for (int c = 0; c < CH; c++) begin
      per[c] = 3 + c;
      cfg_write(c, per[c], 1, 0, 1);
    end
    repeat (120) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_wave", int'(wave), 0);
    check("sync_pulse", int'(pulse), 0);
    for (int c = 0; c < CH; c++) first[c] = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      for (int c = 0; c < CH; c++)
        if (pulse[c] && first[c] < 0) first[c] = k;
    end
    for (int c = 0; c < CH; c++)
      check($sformatf("sync_first_pulse_ch%0d", c), first[c], per[c] + 1);

    // Asynchronous reset mid-run
    cfg_write(2, 0, 1, 0, 1);
    repeat (10) step();
    check("pre_rst_wave2", int'(wave[2]), 1);
    check("pre_rst_pulse2", int'(pulse[2]), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_wave", int'(wave), 0);
    check("async_rst_pulse", int'(pulse), 0);
    #3 rst = 1'b0;
    repeat (10) step();
    check("post_rst_wave", int'(wave), 0);
    check("post_rst_pulse", int'(pulse), 0);
    cfg_write(1, 2, 1, 0, 1);
    wait_pulse(1, 20, n);
    check("post_rst_first_pulse", n, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
